// File: rtl/lynx_video_shifter_if.sv
// Video RAM / CRTC / RGB bundle for the Lynx video shifter.
// Signals:
//   ce    : pixel clock enable (one clock wide)
//   hSync : CRTC horizontal sync, active high
//   de    : CRTC display enable for the current cell
//   altg  : select alt-green plane instead of green
//   d     : video RAM byte for the address selected by bank
//   bank  : plane select to video RAM (00 blue, 01 red, 1x green, bit0 = altg)
//   r/g/b : serialized pixel outputs
interface lynx_video_shifter_if #(
  parameter int unsigned BITS = 8
);
  logic            ce;
  logic            hSync;
  logic            de;
  logic            altg;
  logic [BITS-1:0] d;
  logic [1:0]      bank;
  logic            r;
  logic            g;
  logic            b;

  // CRTC / RAM / display side
  modport master (
    output ce, hSync, de, altg, d,
    input  bank, r, g, b
  );

  // Shifter side
  modport slave (
    input  ce, hSync, de, altg, d,
    output bank, r, g, b
  );
endinterface

// File: rtl/lynx_video_shifter.sv
// Lynx video shifter: fetches blue, red and green/alt-green plane bytes once per
// character cell by stepping the bank select, then serializes the three planes
// MSB first as 1-bit r/g/b, one pixel per ce. Cells with DE low are black, and
// the cell phase realigns on a rising hSync sampled on ce.
// Ports:
//   clock_i : system clock, all state on posedge
//   reset_i : synchronous active-high reset, overrides ce
//   vid     : slave side of lynx_video_shifter_if (ce/hSync/de/altg/d in,
//             bank/r/g/b out)
module lynx_video_shifter #(
  parameter int unsigned BITS = 8,
  parameter int unsigned PHW  = 3
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  lynx_video_shifter_if.slave  vid
);

  localparam logic [PHW-1:0] PH_BLUE = PHW'(0);
  localparam logic [PHW-1:0] PH_RED  = PHW'(1);
  localparam logic [PHW-1:0] PH_GRN  = PHW'(2);
  localparam logic [PHW-1:0] PH_GLAT = PHW'(3);
  localparam logic [PHW-1:0] PH_LAST = PHW'(BITS - 1);

  logic [PHW-1:0]  phase_q, phase_d;
  logic            hs_q, hs_d;
  logic            de_q, de_d;
  logic [BITS-1:0] bl_q, bl_d;
  logic [BITS-1:0] rl_q, rl_d;
  logic [BITS-1:0] gl_q, gl_d;
  logic [BITS-1:0] bs_q, bs_d;
  logic [BITS-1:0] rs_q, rs_d;
  logic [BITS-1:0] gs_q, gs_d;
  logic            r_q, r_d;
  logic            g_q, g_d;
  logic            b_q, b_d;
  logic            resync_c;
  logic [1:0]      bank_c;

  // Plane select follows the phase; altg is read live so it only affects the
  // fetch that starts after it changes.
  always_comb begin
    bank_c = {1'b1, vid.altg};
    if (phase_q == PH_BLUE) begin
      bank_c = 2'b00;
    end else if (phase_q == PH_RED) begin
      bank_c = 2'b01;
    end
  end

  assign resync_c = vid.hSync & ~hs_q;

  // Next-state logic; nothing moves without ce.
  always_comb begin
    phase_d = phase_q;
    hs_d    = hs_q;
    de_d    = de_q;
    bl_d    = bl_q;
    rl_d    = rl_q;
    gl_d    = gl_q;
    bs_d    = bs_q;
    rs_d    = rs_q;
    gs_d    = gs_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;

    if (vid.ce) begin
      hs_d = vid.hSync;

      // Outputs take the MSBs before this ce's load/shift/clear.
      r_d = rs_q[BITS-1];
      g_d = gs_q[BITS-1];
      b_d = bs_q[BITS-1];

      // The byte on d was fetched on the previous ce, one phase behind.
      if (phase_q == PH_BLUE) begin
        de_d = vid.de;
      end
      if (phase_q == PH_RED) begin
        bl_d = vid.d;
      end
      if (phase_q == PH_GRN) begin
        rl_d = vid.d;
      end
      if (phase_q == PH_GLAT) begin
        gl_d = vid.d;
      end

      if (resync_c) begin
        phase_d = PH_BLUE;
        rs_d    = '0;
        gs_d    = '0;
        bs_d    = '0;
      end else begin
        phase_d = phase_q + PHW'(1);
        if (phase_q == PH_LAST) begin
          // Blank cells load black so the border is dark.
          if (de_q) begin
            rs_d = rl_q;
            gs_d = gl_q;
            bs_d = bl_q;
          end else begin
            rs_d = '0;
            gs_d = '0;
            bs_d = '0;
          end
        end else begin
          rs_d = {rs_q[BITS-2:0], 1'b0};
          gs_d = {gs_q[BITS-2:0], 1'b0};
          bs_d = {bs_q[BITS-2:0], 1'b0};
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      phase_q <= '0;
      hs_q    <= 1'b0;
      de_q    <= 1'b0;
      bl_q    <= '0;
      rl_q    <= '0;
      gl_q    <= '0;
      bs_q    <= '0;
      rs_q    <= '0;
      gs_q    <= '0;
      r_q     <= 1'b0;
      g_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      phase_q <= phase_d;
      hs_q    <= hs_d;
      de_q    <= de_d;
      bl_q    <= bl_d;
      rl_q    <= rl_d;
      gl_q    <= gl_d;
      bs_q    <= bs_d;
      rs_q    <= rs_d;
      gs_q    <= gs_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign vid.bank = bank_c;
  assign vid.r    = r_q;
  assign vid.g    = g_q;
  assign vid.b    = b_q;

endmodule

// File: tb/tb_lynx_video_shifter.sv
module tb_lynx_video_shifter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ce_en = 1'b1;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int unsigned ce_cnt = 0;
  logic [7:0] tab [4];

  lynx_video_shifter_if vid ();

  lynx_video_shifter dut (
    .clock_i (clock),
    .reset_i (reset),
    .vid     (vid)
  );

  always #5 clock = ~clock;

  // Pixel enable: one clock in four, suppressible.
  initial begin
    vid.ce = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      ce_cnt = (ce_cnt + 1) % 4;
      vid.ce = ce_en && (ce_cnt == 0);
    end
  end

  // Video RAM: registered read of the selected plane, one pixel slot behind.
  initial begin
    vid.d = 8'h00;
    forever begin
      @(posedge clock);
      if (vid.ce) vid.d <= tab[vid.bank];
    end
  end

  // Behavioural model: cell slot counter, per-cell captured planes and a pixel index.
  int         m_ph  = 0;
  int         m_idx = 8;
  logic       m_hs  = 1'b0;
  logic       m_de  = 1'b0;
  logic       m_r = 1'b0, m_g = 1'b0, m_b = 1'b0;
  logic [7:0] m_cb = 0, m_cr = 0, m_cg = 0;
  logic [7:0] m_pb = 0, m_pr = 0, m_pg = 0;

  task automatic model_step();
    logic rise;
    if (reset) begin
      m_ph = 0; m_idx = 8; m_hs = 0; m_de = 0;
      m_r = 0; m_g = 0; m_b = 0;
      m_cb = 0; m_cr = 0; m_cg = 0; m_pb = 0; m_pr = 0; m_pg = 0;
    end else if (vid.ce) begin
      rise = vid.hSync && !m_hs;
      if (m_idx < 8) begin
        m_r = m_pr[7 - m_idx];
        m_g = m_pg[7 - m_idx];
        m_b = m_pb[7 - m_idx];
      end else begin
        m_r = 0; m_g = 0; m_b = 0;
      end
      case (m_ph)
        0: begin m_de = vid.de; m_cb = tab[0]; end
        1: m_cr = tab[1];
        2: m_cg = vid.altg ? tab[3] : tab[2];
        default: ;
      endcase
      m_hs = vid.hSync;
      if (rise) begin
        m_ph = 0; m_idx = 8;
      end else if (m_ph == 7) begin
        m_ph = 0; m_idx = 0;
        m_pr = m_de ? m_cr : 8'h00;
        m_pg = m_de ? m_cg : 8'h00;
        m_pb = m_de ? m_cb : 8'h00;
      end else begin
        m_ph = m_ph + 1;
        if (m_idx < 8) m_idx = m_idx + 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  initial forever begin
    logic [1:0] eb;
    @(negedge clock);
    if (chk_en) begin
      eb = (m_ph == 0) ? 2'b00 : (m_ph == 1) ? 2'b01 : {1'b1, vid.altg};
      chk("rgb_model", {5'b0, vid.r, vid.g, vid.b}, {5'b0, m_r, m_g, m_b});
      chk("bank_model", {6'b0, vid.bank}, {6'b0, eb});
    end
  end

  task automatic wait_ce(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      do begin
        @(posedge clock);
        t++;
      end while (!vid.ce && t < 64);
      if (!vid.ce) begin
        checks++;
        failures++;
        $display("FAIL ce_timeout actual=none required=ce t=%0t", $time);
      end
      #2;
    end
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    do begin
      wait_ce(1);
      n++;
    end while (m_ph != p && n < 16);
    if (m_ph != p) begin
      checks++;
      failures++;
      $display("FAIL phase_timeout actual=%0d required=%0d", m_ph, p);
    end
  endtask

  task automatic collect(input int n, output logic [7:0] rv, output logic [7:0] gv,
                         output logic [7:0] bv);
    rv = 0; gv = 0; bv = 0;
    for (int i = 0; i < n; i++) begin
      wait_ce(1);
      rv = {rv[6:0], vid.r};
      gv = {gv[6:0], vid.g};
      bv = {bv[6:0], vid.b};
    end
  endtask

  initial begin
    logic [7:0] rv, gv, bv, r2, g2, b2;
    vid.hSync = 1'b0;
    vid.de    = 1'b1;
    vid.altg  = 1'b0;
    tab[0] = 8'hF0; tab[1] = 8'h0F; tab[2] = 8'hAA; tab[3] = 8'h55;

    // Reset held 3 clocks with ce running.
    @(posedge clock); #2;
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #2;
      chk("reset_rgb", {5'b0, vid.r, vid.g, vid.b}, 8'h00);
      chk("reset_bank", {6'b0, vid.bank}, 8'h00);
    end
    reset = 1'b0;

    // First cell: load on the 8th ce, first pixel on the 9th.
    wait_ce(8);
    chk("pre_first_pixel_b", {7'b0, vid.b}, 8'h00);
    wait_ce(1);
    chk("first_pixel_b", {7'b0, vid.b}, 8'h01);

    // Green plane.
    wait_ce(16);
    wait_phase(0);
    collect(8, rv, gv, bv);
    chk("t2_r", rv, 8'h0F);
    chk("t2_g", gv, 8'hAA);
    chk("t2_b", bv, 8'hF0);

    // Alt-green plane.
    vid.altg = 1'b1;
    wait_ce(16);
    wait_phase(2);
    chk("t3_bank", {6'b0, vid.bank}, 8'h03);
    wait_phase(0);
    collect(8, rv, gv, bv);
    chk("t3_g", gv, 8'h55);
    chk("t3_r", rv, 8'h0F);
    vid.altg = 1'b0;

    // One blanked cell between two lit cells.
    tab[0] = 8'hFF; tab[1] = 8'hFF; tab[2] = 8'hFF; tab[3] = 8'hFF;
    wait_ce(16);
    wait_phase(0);
    vid.de = 1'b0;
    collect(1, r2, g2, b2);
    vid.de = 1'b1;
    collect(7, rv, gv, bv);
    chk("t4_prev_cell", {r2[0], rv[6:0]} & {g2[0], gv[6:0]} & {b2[0], bv[6:0]}, 8'hFF);
    collect(8, rv, gv, bv);
    chk("t4_blank_cell", rv | gv | bv, 8'h00);
    collect(8, rv, gv, bv);
    chk("t4_next_cell", rv & gv & bv, 8'hFF);

    // hSync rise at phase 4, then held high.
    tab[0] = 8'hF0; tab[1] = 8'h0F; tab[2] = 8'hAA; tab[3] = 8'h55;
    wait_ce(16);
    wait_phase(4);
    vid.hSync = 1'b1;
    wait_ce(1);
    chk("t5_bank_phase0", {6'b0, vid.bank}, 8'h00);
    wait_ce(1);
    chk("t5_rgb_cleared", {5'b0, vid.r, vid.g, vid.b}, 8'h00);
    wait_ce(24);
    wait_phase(0);
    collect(8, rv, gv, bv);
    chk("t5_b_after", bv, 8'hF0);
    chk("t5_g_after", gv, 8'hAA);
    vid.hSync = 1'b0;

    // ce stalled 20 clocks mid-cell.
    wait_ce(16);
    wait_phase(0);
    collect(3, r2, g2, b2);
    ce_en = 1'b0;
    repeat (20) @(posedge clock);
    ce_en = 1'b1;
    collect(5, rv, gv, bv);
    chk("t6_b_seq", {b2[2:0], bv[4:0]}, 8'hF0);
    chk("t6_r_seq", {r2[2:0], rv[4:0]}, 8'h0F);
    chk("t6_g_seq", {g2[2:0], gv[4:0]}, 8'hAA);

    // Reset mid-cell.
    wait_phase(5);
    reset = 1'b1;
    @(posedge clock); #2;
    chk("t7_reset_rgb", {5'b0, vid.r, vid.g, vid.b}, 8'h00);
    chk("t7_reset_bank", {6'b0, vid.bank}, 8'h00);
    reset = 1'b0;
    wait_ce(20);
    wait_phase(0);
    collect(8, rv, gv, bv);
    chk("t7_b_after", bv, 8'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
